ioctl_load_router: RTL and testbench

//  Generalised successor to the inline DIP-capture and ROM write gating in each arcade top level.

---
 rtl/ioctl_load_router_if.sv | 24 ++
 rtl/ioctl_load_router.sv | 158 +++++++++++++++
 tb/tb_ioctl_load_router.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ioctl_load_router_if.sv
// Download bus between hps_io and the load router: ioctl byte stream in, routed ROM writes out.
interface ioctl_load_router_if #(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 16
);
    logic                   ioctl_download;
    logic [7:0]             ioctl_index;
    logic                   ioctl_wr;
    logic [24:0]            ioctl_addr;
    logic [7:0]             ioctl_dout;
    logic [NUM_REGIONS-1:0] rom_wr;
    logic [ADDR_W-1:0]      rom_addr;
    logic [7:0]             rom_data;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  rom_wr, rom_addr, rom_data
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output rom_wr, rom_addr, rom_data
    );
endinterface

// File: rtl/ioctl_load_router.sv
// Routes the ROM download into address windows, shadows DIP bytes until download end,
// and holds the game core in reset through a download plus a settling interval.
//   state  | meaning
//   S_IDLE | no download, core_reset follows ext_reset
//   S_LOAD | download active
//   S_HOLD | download ended, counting down the reset hold
module ioctl_load_router #(
    parameter logic [7:0] ROM_INDEX = 8'd0,
    parameter logic [7:0] DIP_INDEX = 8'd254,
    parameter int DIP_BYTES = 8,
    parameter logic [DIP_BYTES*8-1:0] DIP_DEFAULT = '0,
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W = 16,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LEN = '1,
    parameter int RESET_HOLD = 255
) (
    input  logic                   clk_sys,
    input  logic                   RESET_N,
    input  logic                   ext_reset,
    ioctl_load_router_if.slave     bus,
    output logic [DIP_BYTES*8-1:0] dip_sw,
    output logic                   dip_valid,
    output logic                   load_err,
    output logic                   dl_done,
    output logic                   core_reset
);
    localparam int CNT_W = (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(RESET_HOLD);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [NUM_REGIONS-1:0] rom_wr_q;
    logic [ADDR_W-1:0]      rom_addr_q;
    logic [7:0]             rom_data_q;
    logic [DIP_BYTES*8-1:0] shadow_q, shadow_d;
    logic [DIP_BYTES*8-1:0] dip_q;
    logic [7:0]             last_idx_q, last_idx_d;
    logic                   dip_valid_q, err_q, dl_done_q, core_reset_q;

    logic [ADDR_W-1:0]      addr_lo, off;
    logic [NUM_REGIONS-1:0] hit;
    logic [ADDR_W:0]        base, lim;
    logic                   hi_zero, one_hot, rom_q, dip_we, rise, fall;

    assign addr_lo = bus.ioctl_addr[ADDR_W-1:0];
    assign hi_zero = (bus.ioctl_addr >> ADDR_W) == 25'd0;
    assign rom_q   = bus.ioctl_wr & bus.ioctl_download & (bus.ioctl_index == ROM_INDEX);
    assign dip_we  = bus.ioctl_wr & (bus.ioctl_index == DIP_INDEX) &
                     (bus.ioctl_addr < 25'(DIP_BYTES));
    assign rise    = bus.ioctl_download & (state_q != S_LOAD);
    assign fall    = ~bus.ioctl_download & (state_q == S_LOAD);
    assign one_hot = (hit != '0) && ((hit & (hit - 1'b1)) == '0);
    assign last_idx_d = bus.ioctl_wr ? bus.ioctl_index : last_idx_q;

    // Window compare carries one extra bit so a window ending at the top of the space cannot wrap.
    always_comb begin
        hit  = '0;
        off  = addr_lo;
        base = '0;
        lim  = '0;
        for (int k = 0; k < NUM_REGIONS; k++) begin
            base = {1'b0, REGION_BASE[k*ADDR_W +: ADDR_W]};
            lim  = base + {1'b0, REGION_LEN[k*ADDR_W +: ADDR_W]};
            if (hi_zero && ({1'b0, addr_lo} >= base) && ({1'b0, addr_lo} < lim)) begin
                hit[k] = 1'b1;
                off    = addr_lo - REGION_BASE[k*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < DIP_BYTES; i++) begin
            if (dip_we && (bus.ioctl_addr == 25'(i))) shadow_d[i*8 +: 8] = bus.ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            cnt_q        <= HOLD_INIT;
            rom_wr_q     <= '0;
            rom_addr_q   <= '0;
            rom_data_q   <= '0;
            shadow_q     <= DIP_DEFAULT;
            dip_q        <= DIP_DEFAULT;
            last_idx_q   <= ~DIP_INDEX;
            dip_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            dl_done_q    <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            rom_wr_q <= (rom_q && one_hot) ? hit : '0;
            if (rom_q) begin
                rom_addr_q <= off;
                rom_data_q <= bus.ioctl_dout;
            end
            err_q <= (err_q & ~(rise & (bus.ioctl_index == ROM_INDEX))) | (rom_q & ~one_hot);

            shadow_q   <= shadow_d;
            last_idx_q <= last_idx_d;
            if (fall && (last_idx_d == DIP_INDEX)) begin
                dip_q       <= shadow_d;
                dip_valid_q <= 1'b1;
            end

            dl_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.ioctl_download) begin
                        state_q      <= S_LOAD;
                        core_reset_q <= 1'b1;
                    end else begin
                        core_reset_q <= ext_reset;
                    end
                end
                S_LOAD: begin
                    core_reset_q <= 1'b1;
                    if (!bus.ioctl_download) begin
                        state_q   <= S_HOLD;
                        cnt_q     <= HOLD_INIT;
                        dl_done_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.ioctl_download) begin
                        state_q      <= S_LOAD;
                        cnt_q        <= HOLD_INIT;
                        core_reset_q <= 1'b1;
                    end else if (cnt_q == '0 || cnt_q == CNT_W'(1)) begin
                        state_q      <= S_IDLE;
                        cnt_q        <= '0;
                        core_reset_q <= ext_reset;
                    end else begin
                        cnt_q        <= cnt_q - 1'b1;
                        core_reset_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    core_reset_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rom_wr   = rom_wr_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_data = rom_data_q;
    assign dip_sw       = dip_q;
    assign dip_valid    = dip_valid_q;
    assign load_err     = err_q;
    assign dl_done      = dl_done_q;
    assign core_reset   = core_reset_q;
endmodule

// File: tb/tb_ioctl_load_router.sv
// Directed plus randomized bench for ioctl_load_router against an address-window reference model.
module tb_ioctl_load_router;
    localparam logic [63:0] DEF = 64'hDEAD_BEEF_0123_4567;
    localparam logic [7:0]  DIPX = 8'd254;
    localparam int BASE [4] = '{'h0000, 'h2000, 'h1F80, 'hF000};
    localparam int LEN  [4] = '{'h2000, 'h0800, 'h0040, 'h1000};

    logic        clk_sys = 1'b0;
    logic        RESET_N;
    logic        ext_reset;
    logic [63:0] dip_sw;
    logic        dip_valid, load_err, dl_done, core_reset;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] shadow_m, dip_m;
    logic        valid_m, err_m, addr_ok_m;
    logic [7:0]  last_idx_m;
    int          exp_addr_m;

    ioctl_load_router_if #(.NUM_REGIONS(4), .ADDR_W(16)) bus ();

    ioctl_load_router #(
        .ROM_INDEX(8'd0), .DIP_INDEX(DIPX), .DIP_BYTES(8), .DIP_DEFAULT(DEF),
        .NUM_REGIONS(4), .ADDR_W(16),
        .REGION_BASE({16'hF000, 16'h1F80, 16'h2000, 16'h0000}),
        .REGION_LEN ({16'h1000, 16'h0040, 16'h0800, 16'h2000}),
        .RESET_HOLD(4)
    ) dut (
        .clk_sys(clk_sys), .RESET_N(RESET_N), .ext_reset(ext_reset), .bus(bus.slave),
        .dip_sw(dip_sw), .dip_valid(dip_valid), .load_err(load_err),
        .dl_done(dl_done), .core_reset(core_reset)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_region(input int addr, output int hv, output int nh, output int off);
        hv = 0; nh = 0; off = 0;
        for (int k = 0; k < 4; k++) begin
            if (addr < 65536 && addr >= BASE[k] && addr < BASE[k] + LEN[k]) begin
                hv |= (1 << k);
                nh++;
                off = addr - BASE[k];
            end
        end
    endfunction

    task automatic rom_step(input int addr, input logic [7:0] d);
        int hv, nh, off;
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(addr); bus.ioctl_dout = d;
        tick;
        bus.ioctl_wr = 1'b0;
        ref_region(addr, hv, nh, off);
        last_idx_m = bus.ioctl_index;
        if (nh != 1) err_m = 1'b1;
        chk("rom_wr", 64'(bus.rom_wr), (nh == 1) ? 64'(hv) : 64'd0);
        chk("rom_data", 64'(bus.rom_data), 64'(d));
        addr_ok_m = (nh == 1);
        if (nh == 1) begin
            exp_addr_m = off;
            chk("rom_addr", 64'(bus.rom_addr), 64'(off));
        end
        chk("load_err", 64'(load_err), 64'(err_m));
    endtask

    task automatic idle_step;
        tick;
        chk("rom_wr_idle", 64'(bus.rom_wr), 64'd0);
        if (addr_ok_m) chk("rom_addr_hold", 64'(bus.rom_addr), 64'(exp_addr_m));
    endtask

    task automatic dip_step(input int addr, input logic [7:0] d);
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(addr); bus.ioctl_dout = d;
        tick;
        bus.ioctl_wr = 1'b0;
        if (addr < 8) shadow_m[addr*8 +: 8] = d;
        last_idx_m = bus.ioctl_index;
        chk("dip_mid_download", dip_sw, dip_m);
        chk("rom_wr_dip", 64'(bus.rom_wr), 64'd0);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.ioctl_index = idx; bus.ioctl_download = 1'b1;
        tick;
        if (idx == 8'd0) err_m = 1'b0;
        chk("core_reset_load", 64'(core_reset), 64'd1);
        chk("load_err_start", 64'(load_err), 64'(err_m));
    endtask

    task automatic end_dl(input bit wr, input int addr, input logic [7:0] d);
        int n;
        bus.ioctl_download = 1'b0; bus.ioctl_wr = wr;
        bus.ioctl_addr = 25'(addr); bus.ioctl_dout = d;
        tick;
        bus.ioctl_wr = 1'b0;
        if (wr) begin
            if (addr < 8) shadow_m[addr*8 +: 8] = d;
            last_idx_m = bus.ioctl_index;
        end
        if (last_idx_m == DIPX) begin
            dip_m = shadow_m;
            valid_m = 1'b1;
        end
        chk("dl_done", 64'(dl_done), 64'd1);
        chk("dip_sw_commit", dip_sw, dip_m);
        chk("dip_valid", 64'(dip_valid), 64'(valid_m));
        n = 0;
        while (core_reset && n < 20) begin
            tick;
            n++;
        end
        chk("core_reset_release", 64'(core_reset), 64'd0);
    endtask

    initial begin
        int hi, dn, post, lows;
        int edges [12] = '{'h1FFF, 'h2000, 'h27FF, 'h2800, 'h1F80, 'h1FBF,
                           'h1FC0, 'hEFFF, 'hF000, 'hFFFF, 'h10000, 'h0000};
        RESET_N = 1'b0; ext_reset = 1'b0;
        bus.ioctl_download = 1'b0; bus.ioctl_index = 8'd0; bus.ioctl_wr = 1'b0;
        bus.ioctl_addr = '0; bus.ioctl_dout = '0;
        shadow_m = DEF; dip_m = DEF; valid_m = 1'b0; err_m = 1'b0;
        addr_ok_m = 1'b0; exp_addr_m = 0; last_idx_m = 8'd0;
        #12;
        chk("rst_rom_wr", 64'(bus.rom_wr), 64'd0);
        chk("rst_rom_addr", 64'(bus.rom_addr), 64'd0);
        chk("rst_rom_data", 64'(bus.rom_data), 64'd0);
        chk("rst_dip_sw", dip_sw, DEF);
        chk("rst_dip_valid", 64'(dip_valid), 64'd0);
        chk("rst_load_err", 64'(load_err), 64'd0);
        chk("rst_dl_done", 64'(dl_done), 64'd0);
        chk("rst_core_reset", 64'(core_reset), 64'd1);
        @(negedge clk_sys);
        RESET_N = 1'b1;
        tick;
        chk("idle_core_reset", 64'(core_reset), 64'd0);
        ext_reset = 1'b1;
        tick;
        chk("ext_reset_on", 64'(core_reset), 64'd1);
        ext_reset = 1'b0;
        tick;
        chk("ext_reset_off", 64'(core_reset), 64'd0);

        // ROM routing: directed window, boundaries, then random addresses
        start_dl(8'd0);
        rom_step('h2005, 8'hA5);
        chk("t1_rom_wr", 64'(bus.rom_wr), 64'h2);
        chk("t1_rom_addr", 64'(bus.rom_addr), 64'h5);
        chk("t1_rom_data", 64'(bus.rom_data), 64'hA5);
        idle_step;
        foreach (edges[i]) rom_step(edges[i], 8'($urandom));
        repeat (60) begin
            rom_step(int'($urandom_range(0, 'h13FFF)), 8'($urandom));
            if ($urandom_range(0, 2) == 0) idle_step;
        end
        rom_step('h3000, 8'h33);
        chk("t3_load_err_set", 64'(load_err), 64'd1);
        end_dl(1'b0, 0, 8'h00);

        // DIP capture: directed bytes, ignored addresses, atomic commit
        start_dl(DIPX);
        for (int i = 0; i < 8; i++) dip_step(i, 8'((i + 1) * 'h11));
        dip_step(8, 8'hEE);
        dip_step(100, 8'hEE);
        chk("t2_mid_dip_sw", dip_sw, DEF);
        chk("t2_mid_valid", 64'(dip_valid), 64'd0);
        end_dl(1'b0, 0, 8'h00);
        chk("t2_byte3", 64'(dip_sw[31:24]), 64'h44);
        chk("t2_load_err_kept", 64'(load_err), 64'd1);

        start_dl(DIPX);
        repeat (10) dip_step(int'($urandom_range(0, 11)), 8'($urandom));
        end_dl(1'b1, 2, 8'($urandom));

        start_dl(8'd0);
        chk("t3_load_err_clear", 64'(load_err), 64'd0);
        rom_step('h0100, 8'h5C);
        end_dl(1'b0, 0, 8'h00);
        chk("rom_dl_no_commit", dip_sw, dip_m);

        // Hold timing: 3 download cycles then RESET_HOLD cycles
        bus.ioctl_index = 8'd5; bus.ioctl_download = 1'b1;
        hi = 0; dn = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) bus.ioctl_download = 1'b0;
            tick;
            if (core_reset) hi++;
            if (dl_done) dn++;
        end
        chk("t4_reset_cycles", 64'(hi), 64'd7);
        chk("t4_dl_done_pulses", 64'(dn), 64'd1);

        // Re-raise during hold: no gap in core_reset, full hold after the second fall
        lows = 0; dn = 0; post = 0;
        bus.ioctl_download = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) bus.ioctl_download = 1'b0;
            if (i == 5) bus.ioctl_download = 1'b1;
            tick;
            if (!core_reset) lows++;
            if (dl_done) dn++;
        end
        bus.ioctl_download = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (core_reset) post++;
            if (dl_done) dn++;
        end
        chk("t5_no_drop", 64'(lows), 64'd0);
        chk("t5_post_hold", 64'(post), 64'd4);
        chk("t5_dl_done_pulses", 64'(dn), 64'd2);

        // Async reset in the middle of a ROM download
        start_dl(8'd0);
        rom_step('h0010, 8'h5A);
        #3 RESET_N = 1'b0;
        #1;
        chk("t6_rom_wr", 64'(bus.rom_wr), 64'd0);
        chk("t6_rom_addr", 64'(bus.rom_addr), 64'd0);
        chk("t6_rom_data", 64'(bus.rom_data), 64'd0);
        chk("t6_dip_sw", dip_sw, DEF);
        chk("t6_dip_valid", 64'(dip_valid), 64'd0);
        chk("t6_load_err", 64'(load_err), 64'd0);
        chk("t6_dl_done", 64'(dl_done), 64'd0);
        chk("t6_core_reset", 64'(core_reset), 64'd1);
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
        RESET_N = 1'b1;
        tick;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
